spi_sample_scheduler: RTL and testbench



---
 rtl/spi_sched_pkg.sv | 12 +
 rtl/spi_sample_scheduler_if.sv | 12 +
 rtl/spi_avg_window.sv | 45 ++++
 rtl/spi_sample_scheduler.sv | 135 +++++++++++++
 tb/tb_spi_sample_scheduler.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/spi_sched_pkg.sv
// rtl/spi_sched_pkg.sv - shared types and constants for the SPI sample scheduler
package spi_sched_pkg;

  localparam int SPI_DW = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } sched_state_e;

endpackage

// File: rtl/spi_sample_scheduler_if.sv
// rtl/spi_sample_scheduler_if.sv - rd/d_ready/d handshake between scheduler and SPI read core
interface spi_sample_scheduler_if;
  import spi_sched_pkg::*;

  logic              spi_rd;
  logic              spi_d_ready;
  logic [SPI_DW-1:0] spi_d;

  modport master (output spi_rd, input spi_d_ready, input spi_d);
  modport slave  (input spi_rd, output spi_d_ready, output spi_d);

endinterface

// File: rtl/spi_avg_window.sv
// rtl/spi_avg_window.sv - circular sample window with running sum and truncated mean
module spi_avg_window
  import spi_sched_pkg::*;
#(
  parameter int AVG_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  input  logic [SPI_DW-1:0] in_data_i,
  output logic [SPI_DW-1:0] avg_o,
  output logic              avg_valid_o
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = SPI_DW + AVG_LOG2;
  localparam logic [AVG_LOG2:0] FILL_LAST = (AVG_LOG2 + 1)'(DEPTH - 1);

  logic [SPI_DW-1:0]   win_q [DEPTH];
  logic [AVG_LOG2-1:0] wr_ptr_q;
  logic [SW-1:0]       sum_q;
  logic [AVG_LOG2:0]   fill_q;
  logic                avg_valid_q;

  // The slot being overwritten is always the oldest, so the sum stays exact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) win_q[i] <= '0;
      wr_ptr_q    <= '0;
      sum_q       <= '0;
      fill_q      <= '0;
      avg_valid_q <= 1'b0;
    end else if (in_valid_i) begin
      win_q[wr_ptr_q] <= in_data_i;
      wr_ptr_q        <= wr_ptr_q + AVG_LOG2'(1);
      sum_q           <= sum_q - SW'(win_q[wr_ptr_q]) + SW'(in_data_i);
      if (!avg_valid_q) fill_q <= fill_q + (AVG_LOG2 + 1)'(1);
      if (fill_q == FILL_LAST) avg_valid_q <= 1'b1;
    end
  end

  assign avg_o       = sum_q[SW-1:AVG_LOG2];
  assign avg_valid_o = avg_valid_q;

endmodule

// File: rtl/spi_sample_scheduler.sv
// rtl/spi_sample_scheduler.sv - periodic SPI read scheduler with capture, averaging and error flags
module spi_sample_scheduler
  import spi_sched_pkg::*;
#(
  parameter int REFRESH_PERIOD = 40_000,
  parameter int TIMEOUT        = 4_096,
  parameter int AVG_LOG2       = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_i,
  input  logic                   clr_err_i,
  spi_sample_scheduler_if.master spi,
  output logic [SPI_DW-1:0]      sample_o,
  output logic                   sample_valid_o,
  output logic [SPI_DW-1:0]      avg_o,
  output logic                   avg_valid_o,
  output logic [15:0]            sample_cnt_o,
  output logic                   timeout_err_o,
  output logic                   overrun_err_o
);

  localparam int PW = $clog2(REFRESH_PERIOD);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0] PER_LAST = PW'(REFRESH_PERIOD - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  sched_state_e      state_q;
  logic              spi_rd_q;
  logic [TW-1:0]     to_cnt_q;
  logic [SPI_DW-1:0] sample_q;
  logic              sample_valid_q;
  logic [15:0]       sample_cnt_q;
  logic              timeout_err_q;

  logic [PW-1:0]     per_cnt_q, per_cnt_d;
  logic              tick_pend_q, tick_pend_d;
  logic              overrun_err_q, overrun_err_d;
  logic              tick;
  logic              consume;

  assign consume = (state_q == IDLE) && tick_pend_q;

  // A tick that lands while one is still pending is an overrun; a new tick beats a clear.
  always_comb begin
    tick          = en_i && (per_cnt_q == PER_LAST);
    per_cnt_d     = per_cnt_q;
    tick_pend_d   = tick_pend_q;
    overrun_err_d = overrun_err_q;
    if (!en_i) begin
      per_cnt_d   = '0;
      tick_pend_d = 1'b0;
    end else begin
      per_cnt_d = tick ? '0 : per_cnt_q + PW'(1);
      if (tick)         tick_pend_d = 1'b1;
      else if (consume) tick_pend_d = 1'b0;
    end
    if (clr_err_i)            overrun_err_d = 1'b0;
    if (tick && tick_pend_q)  overrun_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt_q     <= '0;
      tick_pend_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      per_cnt_q     <= per_cnt_d;
      tick_pend_q   <= tick_pend_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      spi_rd_q       <= 1'b0;
      to_cnt_q       <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      sample_cnt_q   <= '0;
      timeout_err_q  <= 1'b0;
    end else begin
      sample_valid_q <= 1'b0;
      if (clr_err_i) timeout_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (tick_pend_q) begin
            state_q  <= REQ;
            spi_rd_q <= 1'b1;
            to_cnt_q <= '0;
          end
        end
        REQ: begin
          to_cnt_q <= to_cnt_q + TW'(1);
          if (spi.spi_d_ready) begin
            sample_q       <= spi.spi_d;
            sample_valid_q <= 1'b1;
            sample_cnt_q   <= sample_cnt_q + 16'd1;
            spi_rd_q       <= 1'b0;
            state_q        <= RELEASE;
          end else if (to_cnt_q == TO_LAST) begin
            spi_rd_q      <= 1'b0;
            timeout_err_q <= 1'b1;
            state_q       <= RELEASE;
          end
        end
        // Hold here until ready drops so a stale ready cannot satisfy the next request.
        RELEASE: begin
          if (!spi.spi_d_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  spi_avg_window #(
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (sample_valid_q),
    .in_data_i   (sample_q),
    .avg_o       (avg_o),
    .avg_valid_o (avg_valid_o)
  );

  assign spi.spi_rd     = spi_rd_q;
  assign sample_o       = sample_q;
  assign sample_valid_o = sample_valid_q;
  assign sample_cnt_o   = sample_cnt_q;
  assign timeout_err_o  = timeout_err_q;
  assign overrun_err_o  = overrun_err_q;

endmodule

// File: tb/tb_spi_sample_scheduler.sv
// tb/tb_spi_sample_scheduler.sv - randomized bench for spi_sample_scheduler against a transaction-timing model
module tb_spi_sample_scheduler;
  import spi_sched_pkg::*;

  localparam int P  = 16;
  localparam int T  = 8;
  localparam int AL = 2;
  localparam int W  = 1 << AL;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        clr_err = 1'b0;
  logic [15:0] sample, avg, sample_cnt;
  logic        sample_valid, avg_valid, timeout_err, overrun_err;

  spi_sample_scheduler_if spi_if ();

  spi_sample_scheduler #(
    .REFRESH_PERIOD (P),
    .TIMEOUT        (T),
    .AVG_LOG2       (AL)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .en_i           (en),
    .clr_err_i      (clr_err),
    .spi            (spi_if),
    .sample_o       (sample),
    .sample_valid_o (sample_valid),
    .avg_o          (avg),
    .avg_valid_o    (avg_valid),
    .sample_cnt_o   (sample_cnt),
    .timeout_err_o  (timeout_err),
    .overrun_err_o  (overrun_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Model: ticks fall at c0+P-1+kP; a request is issued two cycles after the
  // first unconsumed tick, but never before the FSM is back in IDLE.
  int          c0, pend_from, idle_edge, cnt_m, n_seq;
  bit          to_m, ov_m;
  logic [15:0] hist[$];

  function automatic int first_tick_ge(input int x);
    int b;
    b = c0 + P - 1;
    if (x <= b) return b;
    return b + ((x - b + P - 1) / P) * P;
  endfunction

  function automatic logic [15:0] model_avg();
    int s;
    s = 0;
    foreach (hist[i]) s += int'(hist[i]);
    return 16'(s >> AL);
  endfunction

  task automatic model_restart();
    c0        = cyc;
    pend_from = c0;
    idle_edge = c0;
  endtask

  task automatic do_txn(input bit drop_en, input bit force_seq);
    int          r, d, h, pred, tp, lim, end_c;
    bit          cap, do_clr;
    logic [15:0] data;
    tp   = first_tick_ge(pend_from);
    pred = (tp + 2 > idle_edge + 1) ? tp + 2 : idle_edge + 1;
    if (pred >= tp + P + 1) ov_m = 1'b1;
    lim = 0;
    while (spi_if.spi_rd !== 1'b1 && lim < 300) begin
      @(negedge clk);
      lim++;
    end
    if (lim >= 300) begin
      check_val("rd_rise_wait", 32'(spi_if.spi_rd), 32'd1);
      return;
    end
    r = cyc;
    check_val("issue_cycle", 32'(r), 32'(pred));
    check_val("timeout_err_at_issue", 32'(timeout_err), 32'(to_m));
    check_val("overrun_err_at_issue", 32'(overrun_err), 32'(ov_m));
    pend_from = r - 1;

    d      = force_seq ? int'($urandom_range(0, 3)) : int'($urandom_range(0, T + 1));
    h      = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 40)) : int'($urandom_range(0, 3));
    data   = force_seq ? 16'(4 * (n_seq + 1)) : 16'($urandom);
    cap    = (d < T);
    do_clr = ($urandom_range(0, 3) == 0);
    if (force_seq) n_seq++;
    if (drop_en) en = 1'b0;
    end_c  = cap ? ((h + 1 > 2) ? r + d + h + 1 : r + d + 2) : r + T;

    for (int c = r; c <= end_c; c++) begin
      spi_if.spi_d_ready = cap && (c >= r + d) && (c <= r + d + h);
      spi_if.spi_d       = spi_if.spi_d_ready ? data : 16'($urandom);
      clr_err            = do_clr && (c == r);
      check_val("spi_rd", 32'(spi_if.spi_rd), cap ? 32'(c <= r + d) : 32'(c <= r + T - 1));
      check_val("sample_valid", 32'(sample_valid), 32'(cap && (c == r + d + 1)));
      if (do_clr && c == r + 1) begin
        to_m = 1'b0;
        ov_m = 1'b0;
        check_val("timeout_err_cleared", 32'(timeout_err), 32'd0);
        check_val("overrun_err_cleared", 32'(overrun_err), 32'd0);
      end
      if (cap && c == r + d + 1) begin
        cnt_m = (cnt_m + 1) & 16'hFFFF;
        hist.push_back(data);
        if (hist.size() > W) void'(hist.pop_front());
        check_val("sample", 32'(sample), 32'(data));
        check_val("sample_cnt", 32'(sample_cnt), 32'(cnt_m));
      end
      if (cap && c == r + d + 2) begin
        check_val("avg", 32'(avg), 32'(model_avg()));
        check_val("avg_valid", 32'(avg_valid), 32'(cnt_m >= W));
      end
      if (!cap && c == r + T) begin
        to_m = 1'b1;
        check_val("timeout_err_set", 32'(timeout_err), 32'd1);
        check_val("sample_cnt_on_timeout", 32'(sample_cnt), 32'(cnt_m));
      end
      @(negedge clk);
    end
    spi_if.spi_d_ready = 1'b0;
    clr_err            = 1'b0;
    idle_edge          = cap ? r + d + h + 2 : r + T + 1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_spi_rd"}, 32'(spi_if.spi_rd), 32'd0);
    check_val({tag, "_sample"}, 32'(sample), 32'd0);
    check_val({tag, "_sample_valid"}, 32'(sample_valid), 32'd0);
    check_val({tag, "_avg"}, 32'(avg), 32'd0);
    check_val({tag, "_avg_valid"}, 32'(avg_valid), 32'd0);
    check_val({tag, "_sample_cnt"}, 32'(sample_cnt), 32'd0);
    check_val({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    check_val({tag, "_overrun_err"}, 32'(overrun_err), 32'd0);
  endtask

  initial begin
    int lim;
    spi_if.spi_d_ready = 1'b0;
    spi_if.spi_d       = '0;
    cnt_m = 0;
    n_seq = 0;
    to_m  = 1'b0;
    ov_m  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("por");
    @(negedge clk);
    en = 1'b1;
    model_restart();

    for (int k = 0; k < 40; k++) do_txn(1'b0, k < 5);
    do_txn(1'b1, 1'b0);
    repeat (3 * P) begin
      @(negedge clk);
      check_val("rd_while_disabled", 32'(spi_if.spi_rd), 32'd0);
    end
    en = 1'b1;
    model_restart();
    for (int k = 0; k < 12; k++) do_txn(1'b0, 1'b0);

    lim = 0;
    while (spi_if.spi_rd !== 1'b1 && lim < 300) begin
      @(negedge clk);
      lim++;
    end
    check_val("rd_before_reset", 32'(spi_if.spi_rd), 32'd1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    cnt_m = 0;
    hist.delete();
    to_m = 1'b0;
    ov_m = 1'b0;
    model_restart();
    for (int k = 0; k < 10; k++) do_txn(1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
